// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: latches rising edges into a pending register,
// masks, picks the highest eligible index, and hands it out with a req/ack/eoi handshake.
module irq_controller #(
  parameter int NUM_IRQ = 3,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_IRQ-1:0] r_irq_d;
  logic [NUM_IRQ-1:0] r_pending;
  logic [ID_W-1:0]    r_id;
  logic               r_int_req;
  logic               r_busy;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_clr;
  logic [ID_W-1:0]    w_winner;
  logic               w_ack_taken;

  assign w_rise      = irq & ~r_irq_d;
  assign w_eligible  = r_pending & ~mask;
  assign w_ack_taken = (r_state == REQ) && int_ack;

  // Later indices overwrite earlier ones, so the highest eligible line wins.
  always_comb begin
    w_winner = '0;
    w_clr    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_eligible[i]) w_winner = ID_W'(i);
      w_clr[i] = w_ack_taken && (r_id == ID_W'(i));
    end
  end

  // A fresh edge in the ack cycle is a new event, so the set term dominates the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_d   <= '0;
      r_pending <= '0;
    end else begin
      r_irq_d   <= irq;
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_id      <= '0;
      r_int_req <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_eligible) begin
            r_id      <= w_winner;
            r_int_req <= 1'b1;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            r_int_req <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_int_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign int_req = r_int_req;
  assign int_id  = r_id;
  assign busy    = r_busy;
  assign pending = r_pending;

endmodule

// File: tb/tb_irq_controller.sv
// Directed, table-driven bench for irq_controller with hand sequences for the
// multi-cycle corners (mask hold, level hold, same-cycle re-trigger, reset abort).
module tb_irq_controller;

  logic       clk;
  logic       reset;
  logic [2:0] irq;
  logic [2:0] mask;
  logic       intAck;
  logic       eoi;
  logic       intReq;
  logic [1:0] intId;
  logic       busy;
  logic [2:0] pending;

  int vectorCount;
  int missCount;

  typedef struct {
    logic       rst;
    logic [2:0] irq;
    logic [2:0] mask;
    logic       ack;
    logic       eoi;
    logic       expReq;
    logic [1:0] expId;
    logic       expBusy;
    logic [2:0] expPend;
  } vec_t;

  vec_t vecs[23];

  irq_controller #(.NUM_IRQ(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .mask    (mask),
    .int_ack (intAck),
    .eoi     (eoi),
    .int_req (intReq),
    .int_id  (intId),
    .busy    (busy),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic [2:0] i, input logic [2:0] m,
                               input logic a, input logic e);
    @(negedge clk);
    reset  = r;
    irq    = i;
    mask   = m;
    intAck = a;
    eoi    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic eReq, input logic [1:0] eId,
                             input logic eBusy, input logic [2:0] ePend);
    vectorCount++;
    if (intReq !== eReq || intId !== eId || busy !== eBusy || pending !== ePend) begin
      missCount++;
      $display("[TB] FAIL %s: got req=%b id=%0d busy=%b pend=%b, want req=%b id=%0d busy=%b pend=%b",
               name, intReq, intId, busy, pending, eReq, eId, eBusy, ePend);
    end
  endtask

  initial begin
    int reqCount;
    logic prevReq;
    bit found;

    vectorCount = 0;
    missCount   = 0;
    reset  = 1'b1;
    irq    = '0;
    mask   = '0;
    intAck = 1'b0;
    eoi    = 1'b0;

    //           rst  irq     mask    ack   eoi   req   id     busy  pend
    vecs[0]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
    vecs[1]  = '{1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b001};
    vecs[2]  = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'b001};
    vecs[3]  = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'b000};
    vecs[4]  = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'b000};
    vecs[5]  = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000};
    vecs[6]  = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
    // Simultaneous edges on lines 2 and 0.
    vecs[7]  = '{1'b0, 3'b101, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b101};
    vecs[8]  = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 3'b101};
    vecs[9]  = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 3'b001};
    vecs[10] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3'b001};
    vecs[11] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 3'b001};
    vecs[12] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 3'b000};
    vecs[13] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000};
    // No preemption: line 2 arrives while line 1 is being requested.
    vecs[14] = '{1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b010};
    vecs[15] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 3'b010};
    vecs[16] = '{1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 3'b110};
    vecs[17] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 3'b110};
    vecs[18] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 3'b100};
    vecs[19] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'b100};
    vecs[20] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 3'b100};
    vecs[21] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 3'b000};
    vecs[22] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3'b000};

    for (int v = 0; v < 23; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].irq, vecs[v].mask, vecs[v].ack, vecs[v].eoi);
      checkOutput($sformatf("vec%0d", v), vecs[v].expReq, vecs[v].expId,
                  vecs[v].expBusy, vecs[v].expPend);
    end

    // Mask hold: a masked line still latches but never requests.
    applyStimulus(1'b0, 3'b100, 3'b100, 1'b0, 1'b0);
    checkOutput("mask_latch", 1'b0, 2'd2, 1'b0, 3'b100);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 3'b000, 3'b100, 1'b0, 1'b0);
      checkOutput($sformatf("mask_hold%0d", c), 1'b0, 2'd2, 1'b0, 3'b100);
    end
    found = 1'b0;
    for (int c = 0; c < 2 && !found; c++) begin
      applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
      found = intReq;
    end
    checkOutput("mask_release", 1'b1, 2'd2, 1'b0, 3'b100);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1, 1'b0);
    checkOutput("mask_ack", 1'b0, 2'd2, 1'b1, 3'b000);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
    checkOutput("mask_eoi", 1'b0, 2'd2, 1'b0, 3'b000);

    // Level hold: 20 cycles high, consumer acks and ends immediately; one request only.
    reqCount = 0;
    prevReq  = intReq;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 3'b001, 3'b000, intReq, busy);
      if (intReq && !prevReq) reqCount++;
      prevReq = intReq;
    end
    vectorCount++;
    if (reqCount != 1) begin
      missCount++;
      $display("[TB] FAIL level_hold_count: got %0d requests, want 1", reqCount);
    end
    checkOutput("level_hold_end", 1'b0, 2'd0, 1'b0, 3'b000);

    // Re-trigger: line 0 drops then re-rises in the very cycle it is acknowledged.
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    checkOutput("retrig_low", 1'b0, 2'd0, 1'b0, 3'b000);
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    checkOutput("retrig_edge", 1'b0, 2'd0, 1'b0, 3'b001);
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    checkOutput("retrig_req", 1'b1, 2'd0, 1'b0, 3'b001);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    checkOutput("retrig_drop", 1'b1, 2'd0, 1'b0, 3'b001);
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b1, 1'b0);
    checkOutput("retrig_ack_set", 1'b0, 2'd0, 1'b1, 3'b001);
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b0, 1'b1);
    checkOutput("retrig_eoi", 1'b0, 2'd0, 1'b0, 3'b001);
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    checkOutput("retrig_req2", 1'b1, 2'd0, 1'b0, 3'b001);
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b1, 1'b0);
    checkOutput("retrig_ack2", 1'b0, 2'd0, 1'b1, 3'b000);
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b0, 1'b1);
    checkOutput("retrig_eoi2", 1'b0, 2'd0, 1'b0, 3'b000);

    // Stray ack/eoi in IDLE, then reset while in service with two lines pending.
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b1, 1'b1);
    checkOutput("idle_ignore", 1'b0, 2'd0, 1'b0, 3'b000);
    applyStimulus(1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    checkOutput("abort_edge", 1'b0, 2'd0, 1'b0, 3'b011);
    applyStimulus(1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    checkOutput("abort_req", 1'b1, 2'd1, 1'b0, 3'b011);
    applyStimulus(1'b0, 3'b011, 3'b000, 1'b1, 1'b0);
    checkOutput("abort_ack", 1'b0, 2'd1, 1'b1, 3'b001);
    applyStimulus(1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
    checkOutput("abort_svc", 1'b0, 2'd1, 1'b1, 3'b001);
    applyStimulus(1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    checkOutput("abort_svc_edge", 1'b0, 2'd1, 1'b1, 3'b011);
    applyStimulus(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
    checkOutput("abort_reset", 1'b0, 2'd0, 1'b0, 3'b000);
    applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    checkOutput("abort_after", 1'b0, 2'd0, 1'b0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
